// File: rtl/fifo_pkg.sv
// Shared sizing constants and pointer type for the 16x8 byte FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_THRESH = 8;

  // One wrap bit above the address lets full and empty be told apart.
  typedef logic [FIFO_ADDR_W:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_ram_16x8.sv
// FIFO storage: registered write port, asynchronous read port.
module fifo_ram_16x8
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: storage is deliberately not reset; the pointers alone define
  // which entries are valid, and a reset array would not map to RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_mem_16x8.sv
// Single-clock first-word-fall-through FIFO with full/empty/threshold and
// sticky overflow/underflow status.
module fifo_mem_16x8
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int THRESH = FIFO_THRESH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_threshold,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] THRESH_C = PTR_W'(THRESH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] occupancy;
  logic             wr_en;
  logic             rd_en;

  // Modulo subtraction: correct across the wrap because both pointers
  // carry the extra MSB.
  assign occupancy      = wr_ptr - rd_ptr;
  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_full      = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                          (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign fifo_threshold = (occupancy >= THRESH_C);

  assign wr_en = wr & ~fifo_full;
  assign rd_en = rd & ~fifo_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge flags, giving the simultaneous wr/rd behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;

      // Set wins over clear when both happen on the same edge.
      if (wr && fifo_full)  fifo_overflow <= 1'b1;
      else if (rd_en)       fifo_overflow <= 1'b0;

      if (rd && fifo_empty) fifo_underflow <= 1'b1;
      else if (wr_en)       fifo_underflow <= 1'b0;
    end
  end

  fifo_ram_16x8 #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(data_in),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(data_out)
  );

endmodule

// File: tb/tb_fifo_mem_16x8.sv
// Directed bench for fifo_mem_16x8: fill, overflow, drain, underflow,
// wrap under concurrent traffic, simultaneous ops at full/empty, reset.
module tb_fifo_mem_16x8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_threshold;
  logic       fifo_overflow;
  logic       fifo_underflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_mem_16x8 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr            (wr),
    .rd            (rd),
    .data_in       (data_in),
    .data_out      (data_out),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_threshold(fifo_threshold),
    .fifo_overflow (fifo_overflow),
    .fifo_underflow(fifo_underflow)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic e, input logic f,
                       input logic t, input logic o, input logic u);
    check({tag, ".empty"},     fifo_empty,     e);
    check({tag, ".full"},      fifo_full,      f);
    check({tag, ".threshold"}, fifo_threshold, t);
    check({tag, ".overflow"},  fifo_overflow,  o);
    check({tag, ".underflow"}, fifo_underflow, u);
  endtask

  initial begin
    // Reset held for two edges.
    rst_n = 1'b0;
    step();
    step();
    flags("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Fill with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; data_in = 8'(i);
      step();
      check($sformatf("fill%0d.empty", i), fifo_empty, 1'b0);
      check($sformatf("fill%0d.threshold", i), fifo_threshold, i >= 8);
      check($sformatf("fill%0d.full", i), fifo_full, i == 16);
      check($sformatf("fill%0d.head", i), data_out, 8'h01);
    end

    // Write while full: dropped, overflow sets.
    data_in = 8'h11;
    step();
    wr = 1'b0;
    check("ovf.overflow", fifo_overflow, 1'b1);
    check("ovf.full", fifo_full, 1'b1);
    check("ovf.head", data_out, 8'h01);

    // Drain 17 reads; the last one underflows.
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) check($sformatf("drain%0d.data", i), data_out, 8'(i));
      rd = 1'b1;
      step();
      rd = 1'b0;
      if (i == 1) check("drain1.overflow_clr", fifo_overflow, 1'b0);
      check($sformatf("drain%0d.empty", i), fifo_empty, i >= 16);
      check($sformatf("drain%0d.threshold", i), fifo_threshold, i <= 8);
      check($sformatf("drain%0d.underflow", i), fifo_underflow, i == 17);
    end

    // A following write clears underflow.
    wr = 1'b1; data_in = 8'hA5;
    step();
    wr = 1'b0;
    check("uclr.underflow", fifo_underflow, 1'b0);
    check("uclr.head", data_out, 8'hA5);
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("uclr.empty", fifo_empty, 1'b1);

    // Preload 4, then 40 cycles of simultaneous write+read across the wrap.
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; data_in = 8'h20 + 8'(i);
      step();
    end
    rd = 1'b1;
    for (int k = 0; k < 40; k++) begin
      check($sformatf("wrap%0d.data", k), data_out, 8'h20 + 8'(k));
      data_in = 8'h24 + 8'(k);
      step();
      check($sformatf("wrap%0d.empty", k), fifo_empty, 1'b0);
      check($sformatf("wrap%0d.full", k), fifo_full, 1'b0);
      check($sformatf("wrap%0d.threshold", k), fifo_threshold, 1'b0);
    end
    wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tail%0d.data", i), data_out, 8'h48 + 8'(i));
      step();
    end
    rd = 1'b0;
    check("tail.empty", fifo_empty, 1'b1);
    check("tail.underflow", fifo_underflow, 1'b0);

    // Mid-operation reset, asserted together with a write.
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; data_in = 8'h60 + 8'(i);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wr = 1'b0;
    flags("midrst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rd = 1'b1;
    step();
    rd = 1'b0;
    flags("midrst_rd", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Write+read while empty: write accepted, read ignored, underflow set.
    wr = 1'b1; rd = 1'b1; data_in = 8'h77;
    step();
    rd = 1'b0;
    flags("wr_rd_empty", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("wr_rd_empty.head", data_out, 8'h77);

    // Fill to 16, then write+read while full: read accepted, write dropped.
    for (int i = 1; i <= 15; i++) begin
      data_in = 8'h80 + 8'(i);
      step();
    end
    flags("refill", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    rd = 1'b1; data_in = 8'hEE;
    step();
    wr = 1'b0; rd = 1'b0;
    flags("wr_rd_full", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("wr_rd_full.head", data_out, 8'h81);

    // The dropped 0xEE must never appear; the last entry is 0x8F.
    rd = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      check($sformatf("final%0d.data", i), data_out, 8'h80 + 8'(i));
      step();
    end
    rd = 1'b0;
    check("final.empty", fifo_empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_mem_16x8.md
# fifo_mem_16x8

Synchronous single-clock FIFO: 16 entries × 8 bits, with full, empty, half-threshold, overflow and underflow status. It buffers byte streams between producer and consumer logic running on the same clock. The read port is first-word-fall-through: the head entry is always visible on `data_out`.

## Interface
Parameters:
- `DATA_W`, default 8: data width in bits.
- `DEPTH`, default 16: number of entries; must be a power of two.
- `THRESH`, default 8: occupancy at or above which `fifo_threshold` asserts.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `wr`, input, 1: write request; `data_in` is sampled on the same edge.
- `rd`, input, 1: read request; pops the head entry.
- `data_in`, input, `DATA_W`: write data.
- `data_out`, output, `DATA_W`: current head entry, combinational from memory.
- `fifo_full`, output, 1: occupancy equals `DEPTH`.
- `fifo_empty`, output, 1: occupancy equals 0.
- `fifo_threshold`, output, 1: occupancy is at least `THRESH`.
- `fifo_overflow`, output, 1: sticky flag; a write was attempted while full.
- `fifo_underflow`, output, 1: sticky flag; a read was attempted while empty.

## Operation
- Pointers:
  - `wr_ptr` and `rd_ptr` are each log2(`DEPTH`)+1 bits wide. The extra MSB is a wrap bit.
  - Low bits address the memory. Both pointers wrap naturally from 31 to 0.
- Occupancy is `wr_ptr - rd_ptr`, taken modulo 2^(log2(`DEPTH`)+1).
- Flags:
  - `fifo_empty` = pointers equal.
  - `fifo_full` = low bits equal and MSBs differ.
  - `fifo_threshold` = occupancy ≥ `THRESH`.
- Accepted write is `wr & ~fifo_full`: writes `mem[wr_ptr]` with `data_in` and increments `wr_ptr`.
- Accepted read is `rd & ~fifo_empty`: increments `rd_ptr`. Data is taken from `data_out` before the edge.
- Simultaneous `wr` and `rd`, with flags evaluated before the edge:
  - Neither full nor empty: both are accepted and occupancy is unchanged.
  - Full: the read is accepted and the write is dropped (overflow sets).
  - Empty: the write is accepted and the read is ignored (underflow sets).
- `fifo_overflow`:
  - Set on an edge with `wr & fifo_full`.
  - Cleared on an accepted read, or by reset.
  - Set has priority over clear.
- `fifo_underflow`:
  - Set on an edge with `rd & fifo_empty`.
  - Cleared on an accepted write, or by reset.
  - Set has priority over clear.
- A dropped write or ignored read changes neither pointers nor memory.
- `data_out` is `mem[rd_ptr[3:0]]` at all times. When empty it shows stale or uninitialised contents; this is not a defect.

## Timing
- Reset: when `rst_n`=0 at a rising edge, the next state is:
  - pointers 0
  - `fifo_empty`=1, `fifo_full`=0, `fifo_threshold`=0
  - `fifo_overflow`=0, `fifo_underflow`=0
- Reset has priority over `wr` and `rd` in the same cycle. Memory contents are not reset.
- A reset mid-operation discards all contents immediately at that edge.
- Write-to-read latency: data written at edge N appears on `data_out` right after edge N if the FIFO was empty. It can be popped at edge N+1.
- Read: `data_out` changes to the next entry combinationally after the popping edge.
- Full, empty and threshold are combinational from registered pointers, so they are valid in the cycle after the causing edge. Overflow and underflow are registered.
- One write and/or one read per cycle. No handshake beyond the flags.

## Structure
- Shared package `fifo_pkg`:
  - localparams `FIFO_DATA_W`=8, `FIFO_DEPTH`=16, `FIFO_ADDR_W`=4, `FIFO_THRESH`=8.
  - Typedef `fifo_ptr_t` of width `FIFO_ADDR_W`+1.
- Sub-module `fifo_ram_16x8`: write port registered on `clk` with write enable; read port asynchronous. Storage is a plain register array with no reset.
- The top level holds pointer registers, flag logic and the sticky-flag registers.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles -> `fifo_empty`=1, `fifo_full`=0, `fifo_threshold`=0, `fifo_overflow`=0, `fifo_underflow`=0.
- Fill: write 0x01 to 0x10 (16 single-cycle `wr` pulses).
  - `fifo_threshold` rises after the 8th write.
  - `fifo_full` rises after the 16th write.
  - `fifo_empty` falls after the 1st write.
- Overflow: with the FIFO full, write 0x11 -> `fifo_overflow`=1, contents unchanged.
  - The first read clears `fifo_overflow`.
  - 0x11 is never read out.
- Drain: issue 17 single-cycle `rd` pulses.
  - First 16 reads return 0x01 to 0x10 in order on `data_out` before each popping edge.
  - `fifo_empty` rises after the 16th read.
  - The 17th read sets `fifo_underflow`; a following write clears it.
- Wrap and concurrency:
  - Preload 4 entries, then assert `wr`+`rd` for 40 cycles with incrementing data.
  - Occupancy stays at 4 and the pointers wrap.
  - Output order stays strictly FIFO.
- Mid-operation reset: write 5 entries, assert `rst_n`=0 for one edge -> `fifo_empty`=1 and a subsequent read sets `fifo_underflow`.
